// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared state encoding, transfer-size codes and the request record
//            used by mem_bus_arbiter and mem_req_slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] BHW_BYTE = 3'd1;
  localparam logic [2:0] BHW_HALF = 3'd2;
  localparam logic [2:0] BHW_WORD = 3'd4;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam int TIMEOUT_CNT_W = 13;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [2:0]  bhw;
    logic        write_notread;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_slot.sv
// ============================================================================
// Module   : mem_req_slot
// Purpose  : One-deep request holding register for a single bus master, with
//            ready/capture/free handshake and dropped-request flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_slot
  import mem_bus_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_dv,
  input  mem_req_t i_req,
  input  logic     i_free,
  output logic     o_ready,
  output logic     o_full,
  output mem_req_t o_req,
  output logic     o_drop
);

  logic     r_full;
  mem_req_t r_req;

  // A capture only happens into an empty slot, and a free only targets a
  // full one, so the two can never collide in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (i_dv && !r_full) begin
      r_full <= 1'b1;
      r_req  <= i_req;
    end else if (i_free) begin
      r_full <= 1'b0;
    end
  end

  assign o_ready = ~r_full;
  assign o_full  = r_full;
  assign o_req   = r_req;
  assign o_drop  = i_dv & r_full;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master (fetch / load-store) arbiter for the byte-sequenced
//            memory bus. Optional watchdog in WAIT enabled by ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int RR_EN          = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_DV,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_data,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write_notread,
  output logic        o_m0_ready,
  output logic [31:0] o_m0_data,
  output logic        o_m0_DV,
  input  logic        i_m1_DV,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_data,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write_notread,
  output logic        o_m1_ready,
  output logic [31:0] o_m1_data,
  output logic        o_m1_DV,
  output logic        o_mem_DV,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_data,
  output logic [2:0]  o_mem_bhw,
  output logic        o_mem_write_notread,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_DV,
  output logic        o_err
);

  mem_req_t    w_req_in   [2];
  mem_req_t    w_slot_req [2];
  logic [1:0]  w_dv_in;
  logic [1:0]  w_full;
  logic [1:0]  w_ready;
  logic [1:0]  w_drop;
  logic [1:0]  w_free;
  logic        w_pick;
  logic        w_done;
  logic        w_timeout;
  logic [31:0] w_resp_data;

  logic [1:0]  r_state;
  logic        r_grant;
  logic        r_last;
  logic        r_mem_dv;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_data;
  logic [2:0]  r_mem_bhw;
  logic        r_mem_write_notread;
  logic [1:0]  r_m_dv;
  logic [31:0] r_m0_data;
  logic [31:0] r_m1_data;
  logic        r_err;

  assign w_dv_in     = {i_m1_DV, i_m0_DV};
  assign w_req_in[0] = {i_m0_address, i_m0_data, i_m0_bhw, i_m0_write_notread};
  assign w_req_in[1] = {i_m1_address, i_m1_data, i_m1_bhw, i_m1_write_notread};

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    mem_req_slot u_slot (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_dv    (w_dv_in[gi]),
      .i_req   (w_req_in[gi]),
      .i_free  (w_free[gi]),
      .o_ready (w_ready[gi]),
      .o_full  (w_full[gi]),
      .o_req   (w_slot_req[gi]),
      .o_drop  (w_drop[gi])
    );
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] c_timeout_limit = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == c_timeout_limit);
`else
  localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
`endif

  // Both pending: round-robin hands the bus to the master not served last;
  // fixed priority always favours load/store.
  always_comb begin
    w_pick = w_full[1];
    if (w_full[1] && w_full[0]) begin
      w_pick = (RR_EN != 0) ? ~r_last : 1'b1;
    end
  end

  assign w_done      = (r_state == ST_WAIT) && (i_mem_DV || w_timeout);
  assign w_free      = w_done ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_resp_data = !i_mem_DV            ? TIMEOUT_DATA :
                       r_mem_write_notread  ? 32'h0        : i_mem_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state             <= ST_IDLE;
      r_grant             <= 1'b0;
      r_last              <= 1'b0;
      r_mem_dv            <= 1'b0;
      r_mem_address       <= '0;
      r_mem_data          <= '0;
      r_mem_bhw           <= '0;
      r_mem_write_notread <= 1'b0;
      r_m_dv              <= 2'b00;
      r_m0_data           <= '0;
      r_m1_data           <= '0;
      r_err               <= 1'b0;
    end else begin
      r_mem_dv <= 1'b0;
      r_m_dv   <= 2'b00;
      if ((|w_drop) || w_timeout) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (|w_full) begin
            r_grant             <= w_pick;
            r_mem_dv            <= 1'b1;
            r_mem_address       <= w_slot_req[w_pick].address;
            r_mem_data          <= w_slot_req[w_pick].data;
            r_mem_bhw           <= w_slot_req[w_pick].bhw;
            r_mem_write_notread <= w_slot_req[w_pick].write_notread;
            r_state             <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            r_m_dv[r_grant] <= 1'b1;
            if (r_grant) begin
              r_m1_data <= w_resp_data;
            end else begin
              r_m0_data <= w_resp_data;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_last  <= r_grant;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_m0_ready          = w_ready[0];
  assign o_m1_ready          = w_ready[1];
  assign o_m0_DV             = r_m_dv[0];
  assign o_m1_DV             = r_m_dv[1];
  assign o_m0_data           = r_m0_data;
  assign o_m1_data           = r_m1_data;
  assign o_mem_DV            = r_mem_dv;
  assign o_mem_address       = r_mem_address;
  assign o_mem_data          = r_mem_data;
  assign o_mem_bhw           = r_mem_bhw;
  assign o_mem_write_notread = r_mem_write_notread;
  assign o_err               = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter (round-robin and fixed
//            priority instances); timeout checks follow ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  m_dv, m_wr, m_ready, m_rdv;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_rdata[2];
  logic [2:0]  m_bhw  [2];
  logic        mem_dv, mem_wr, mem_rdv, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_bhw;

  logic [1:0]  f_dv, f_ready, f_rdv;
  logic [31:0] f_addr [2];
  logic [31:0] f_rdata[2];
  logic        f_mem_dv, f_mem_wr, f_mem_rdv, f_err;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [2:0]  f_mem_bhw;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(.RR_EN(1), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_DV(m_dv[0]), .i_m0_address(m_addr[0]), .i_m0_data(m_wdata[0]),
    .i_m0_bhw(m_bhw[0]), .i_m0_write_notread(m_wr[0]),
    .o_m0_ready(m_ready[0]), .o_m0_data(m_rdata[0]), .o_m0_DV(m_rdv[0]),
    .i_m1_DV(m_dv[1]), .i_m1_address(m_addr[1]), .i_m1_data(m_wdata[1]),
    .i_m1_bhw(m_bhw[1]), .i_m1_write_notread(m_wr[1]),
    .o_m1_ready(m_ready[1]), .o_m1_data(m_rdata[1]), .o_m1_DV(m_rdv[1]),
    .o_mem_DV(mem_dv), .o_mem_address(mem_addr), .o_mem_data(mem_wdata),
    .o_mem_bhw(mem_bhw), .o_mem_write_notread(mem_wr),
    .i_mem_data(mem_rdata), .i_mem_DV(mem_rdv), .o_err(err)
  );

  mem_bus_arbiter #(.RR_EN(0), .TIMEOUT_CYCLES(16)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_DV(f_dv[0]), .i_m0_address(f_addr[0]), .i_m0_data(32'h0),
    .i_m0_bhw(BHW_WORD), .i_m0_write_notread(1'b0),
    .o_m0_ready(f_ready[0]), .o_m0_data(f_rdata[0]), .o_m0_DV(f_rdv[0]),
    .i_m1_DV(f_dv[1]), .i_m1_address(f_addr[1]), .i_m1_data(32'h0),
    .i_m1_bhw(BHW_WORD), .i_m1_write_notread(1'b0),
    .o_m1_ready(f_ready[1]), .o_m1_data(f_rdata[1]), .o_m1_DV(f_rdv[1]),
    .o_mem_DV(f_mem_dv), .o_mem_address(f_mem_addr), .o_mem_data(f_mem_wdata),
    .o_mem_bhw(f_mem_bhw), .o_mem_write_notread(f_mem_wr),
    .i_mem_data(32'h5555_5555), .i_mem_DV(f_mem_rdv), .o_err(f_err)
  );

  typedef struct packed {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  bhw;
    logic [31:0] resp;
    logic [7:0]  delay;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Spacing between memory requests on the round-robin instance.
  int cyc = 0;
  int last_issue = -100;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_issue = -100;
    end else if (mem_dv) begin
      check("mem_gap_ge3", 32'(cyc - last_issue >= 3), 32'd1);
      last_issue = cyc;
    end
  end

  task automatic request(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] b, input logic w);
    m_dv[m] = 1'b1; m_addr[m] = a; m_wdata[m] = d; m_bhw[m] = b; m_wr[m] = w;
  endtask

  task automatic wait_mem(input string nm);
    int n = 0;
    while (!mem_dv && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_issue"}, mem_dv, 1);
  endtask

  task automatic serve(input string nm, input logic [31:0] exp_addr,
                       input logic [31:0] resp, input int exp_m);
    wait_mem(nm);
    check({nm, "_addr"}, mem_addr, exp_addr);
    tick();
    mem_rdv = 1'b1; mem_rdata = resp;
    tick();
    mem_rdv = 1'b0;
    check({nm, "_dv"}, m_rdv[exp_m], 1);
    check({nm, "_dv_other"}, m_rdv[1-exp_m], 0);
    check({nm, "_data"}, m_rdata[exp_m], resp);
    check({nm, "_ready"}, m_ready[exp_m], 1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm = $sformatf("vec%0d", i);
    request(int'(v.m), v.addr, v.wdata, v.bhw, v.wr);
    tick();
    m_dv = 2'b00;
    check({nm, "_ready_low"}, m_ready[v.m], 0);
    check({nm, "_mem_dv_early"}, mem_dv, 0);
    tick();
    check({nm, "_mem_dv_lat2"}, mem_dv, 1);
    check({nm, "_mem_addr"}, mem_addr, v.addr);
    check({nm, "_mem_data"}, mem_wdata, v.wdata);
    check({nm, "_mem_bhw"}, 32'(mem_bhw), 32'(v.bhw));
    check({nm, "_mem_wr"}, mem_wr, v.wr);
    repeat (int'(v.delay)) tick();
    mem_rdv = 1'b1; mem_rdata = v.resp;
    tick();
    mem_rdv = 1'b0; mem_rdata = 32'h0;
    check({nm, "_resp_dv"}, m_rdv[v.m], 1);
    check({nm, "_resp_other"}, m_rdv[~v.m], 0);
    check({nm, "_resp_data"}, m_rdata[v.m], v.exp_data);
    check({nm, "_ready_resp"}, m_ready[v.m], 1);
    tick();
    check({nm, "_resp_pulse"}, m_rdv[v.m], 0);
    tick();
  endtask

  // Transaction-level model: each master owns at most one outstanding
  // request; memory serves one transfer at a time after a random delay.
  task automatic run_random();
    bit          out[2] = '{0, 0};
    bit          due[2] = '{0, 0};
    logic [31:0] q_addr[2], q_data[2], q_exp[2];
    logic [2:0]  q_bhw[2];
    logic        q_wr[2];
    bit          busy = 0;
    int          owner = 0, dly = 0, o;
    for (int c = 0; c < 900; c++) begin
      if (mem_dv) begin
        o = int'(mem_addr[31]);
        check("rnd_one_at_a_time", 32'(busy), 0);
        check("rnd_owner_pending", 32'(out[o]), 1);
        check("rnd_addr", mem_addr, q_addr[o]);
        check("rnd_wdata", mem_wdata, q_data[o]);
        check("rnd_bhw", 32'(mem_bhw), 32'(q_bhw[o]));
        check("rnd_wr", mem_wr, q_wr[o]);
        busy = 1; owner = o; dly = $urandom_range(1, 5);
        q_exp[o] = q_wr[o] ? 32'h0 : $urandom;
      end
      for (int m = 0; m < 2; m++) begin
        check("rnd_resp_dv", m_rdv[m], 32'(due[m]));
        if (m_rdv[m] && due[m]) begin
          check("rnd_resp_data", m_rdata[m], q_exp[m]);
          out[m] = 0;
        end
        due[m] = 0;
        check("rnd_ready", m_ready[m], 32'(!out[m]));
      end
      mem_rdv = 1'b0;
      if (busy) begin
        if (dly == 0) begin
          mem_rdv = 1'b1;
          mem_rdata = q_wr[owner] ? $urandom : q_exp[owner];
          busy = 0; due[owner] = 1;
        end else begin
          dly--;
        end
      end
      for (int m = 0; m < 2; m++) begin
        m_dv[m] = 1'b0;
        if (!out[m] && c < 800 && $urandom_range(0, 2) == 0) begin
          q_addr[m] = {1'(m), 31'($urandom)};
          q_data[m] = $urandom;
          case ($urandom_range(0, 2))
            0:       q_bhw[m] = BHW_BYTE;
            1:       q_bhw[m] = BHW_HALF;
            default: q_bhw[m] = BHW_WORD;
          endcase
          q_wr[m] = 1'($urandom);
          request(m, q_addr[m], q_data[m], q_bhw[m], q_wr[m]);
          out[m] = 1;
        end
      end
      tick();
    end
    mem_rdv = 1'b0;
    check("rnd_drained", {30'h0, out[1], out[0]}, 0);
    check("rnd_no_err", err, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   n;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,    BHW_WORD, 32'h1234_5678, 8'd5, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hAB,   BHW_BYTE, 32'hFFFF_FFFF, 8'd2, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0202, 32'hBEEF, BHW_HALF, 32'h0BAD_0BAD, 8'd1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h8000_0404, 32'h77,   3'd3,     32'hCAFE_F00D, 8'd3, 32'hCAFE_F00D};

    m_dv = 2'b00; m_wr = 2'b00;
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_wdata[m] = '0; m_bhw[m] = '0;
      f_addr[m] = '0;
    end
    mem_rdv = 1'b0; mem_rdata = '0; f_dv = 2'b00; f_mem_rdv = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_m0_ready", m_ready[0], 1);
    check("rst_m1_ready", m_ready[1], 1);
    check("rst_mem_dv", mem_dv, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_bhw", 32'(mem_bhw), 0);
    check("rst_m_dv", 32'(m_rdv), 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Simultaneous requests after reset: pointer at M0, so M1 goes first.
    request(0, 32'h0000_1000, 32'h0, BHW_WORD, 1'b0);
    request(1, 32'h8000_2000, 32'h0, BHW_WORD, 1'b0);
    tick();
    m_dv = 2'b00;
    serve("rr1_first", 32'h8000_2000, 32'h1111_1111, 1);
    serve("rr1_second", 32'h0000_1000, 32'h2222_2222, 0);
    tick(); tick();

    // M1 served alone, then both re-request during its response cycle.
    request(1, 32'h8000_3000, 32'h0, BHW_WORD, 1'b0);
    tick();
    m_dv = 2'b00;
    serve("rr2_m1_alone", 32'h8000_3000, 32'h3333_0000, 1);
    request(0, 32'h0000_4000, 32'h0, BHW_WORD, 1'b0);
    request(1, 32'h8000_4000, 32'h0, BHW_WORD, 1'b0);
    tick();
    m_dv = 2'b00;
    serve("rr2_first_m0", 32'h0000_4000, 32'h4444_0000, 0);
    serve("rr2_second_m1", 32'h8000_4000, 32'h4444_0001, 1);
    tick(); tick();

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    run_random();
    repeat (4) tick();

    // Second pulse while the slot is full is dropped and flags an error.
    request(1, 32'h8000_0300, 32'h0, BHW_WORD, 1'b0);
    tick();
    check("drop_ready_low", m_ready[1], 0);
    check("drop_err_before", err, 0);
    request(1, 32'h8000_0400, 32'h0, BHW_WORD, 1'b0);
    tick();
    m_dv = 2'b00;
    check("drop_err_set", err, 1);
    serve("drop_served_first", 32'h8000_0300, 32'h3333_3333, 1);
    tick();
    check("drop_err_sticky", err, 1);
    tick(); tick();

    // Reset while waiting for memory.
    request(0, 32'h0000_0500, 32'h0, BHW_WORD, 1'b0);
    tick();
    m_dv = 2'b00;
    wait_mem("rstw");
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstw_mem_addr", mem_addr, 0);
    check("rstw_m0_ready", m_ready[0], 1);
    check("rstw_m1_ready", m_ready[1], 1);
    check("rstw_m1_data", m_rdata[1], 0);
    check("rstw_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rdv = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    mem_rdv = 1'b0;
    n = 0;
    repeat (6) begin
      if (m_rdv != 2'b00 || mem_dv) n++;
      tick();
    end
    check("rstw_quiet_after", n, 0);

    request(0, 32'h0000_0600, 32'h0, BHW_WORD, 1'b0);
    tick();
    m_dv = 2'b00;
    wait_mem("tmo");
    n = 0;
`ifdef ARB_TIMEOUT_EN
    while (!m_rdv[0] && n < 40) begin
      tick();
      n++;
    end
    check("tmo_dv", m_rdv[0], 1);
    check("tmo_latency_16_19", 32'(n >= 16 && n <= 19), 1);
    check("tmo_data", m_rdata[0], TIMEOUT_DATA);
    check("tmo_err", err, 1);
`else
    repeat (40) begin
      tick();
      if (m_rdv != 2'b00) n++;
    end
    check("wait_holds", n, 0);
    check("wait_ready_low", m_ready[0], 0);
    mem_rdv = 1'b1; mem_rdata = 32'h6666_6666;
    tick();
    mem_rdv = 1'b0;
    check("wait_late_dv", m_rdv[0], 1);
    check("wait_late_data", m_rdata[0], 32'h6666_6666);
`endif
    tick(); tick();

    // Fixed priority: M1 keeps re-requesting and wins every round.
    f_addr[0] = 32'h0000_0700; f_addr[1] = 32'h8000_0700;
    f_dv = 2'b11;
    tick();
    f_dv = 2'b00;
    for (int r = 0; r < 6; r++) begin
      n = 0;
      while (!f_mem_dv && n < 50) begin
        tick();
        n++;
      end
      check("fp_issue", f_mem_dv, 1);
      check("fp_winner", 32'(f_mem_addr[31]), (r < 5) ? 32'd1 : 32'd0);
      if (r < 5) check("fp_m0_waiting", f_ready[0], 0);
      tick();
      f_mem_rdv = 1'b1;
      tick();
      f_mem_rdv = 1'b0;
      check("fp_resp", 32'(f_rdv), (r < 5) ? 32'd2 : 32'd1);
      if (r < 4) begin
        f_dv[1] = 1'b1; f_addr[1] = 32'h8000_0710 + 32'(r);
        tick();
        f_dv = 2'b00;
      end
    end
    check("fp_no_err", f_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
